sdram_rd_fifo: RTL and testbench

//  Read-side counterpart of the USB->SDRAM write path, in the sdram_clk domain.
//  On a start pulse, reads LEN consecutive words from SDRAM via the rd_addr/rd_valid/rd_ready request

---
 rtl/sdram_rd_fifo_pkg.sv | 19 +
 rtl/sdram_rd_fifo_if.sv | 33 +++
 rtl/sdram_rd_fifo_skid.sv | 50 +++++
 rtl/sdram_rd_fifo.sv | 110 +++++++++++
 tb/tb_sdram_rd_fifo.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_rd_fifo_pkg.sv
// Shared definitions for the SDRAM read path: default widths, FSM encoding and
// a helper for sizing counters that must hold 0..N inclusive.
package sdram_rd_fifo_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sdram_rd_fifo_if.sv
// Read-request channel towards the SDRAM controller plus the write port of the
// SDRAM->USB async FIFO; master is the read engine, slave is the memory/FIFO side.
interface sdram_rd_fifo_if
  import sdram_rd_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_rvalid;
  logic              fifo_wen;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_wfull;

  modport master (
    output rd_addr, rd_valid,
    input  rd_ready, rd_rdata, rd_rvalid,
    output fifo_wen, fifo_wdata,
    input  fifo_wfull
  );

  modport slave (
    input  rd_addr, rd_valid,
    output rd_ready, rd_rdata, rd_rvalid,
    input  fifo_wen, fifo_wdata,
    output fifo_wfull
  );

endinterface

// File: rtl/sdram_rd_fifo_skid.sv
// Return buffer for read data: a small synchronous FIFO whose depth equals the
// number of credits, so it can never be pushed while full.
module sdram_rd_fifo_skid
  import sdram_rd_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         din,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/sdram_rd_fifo.sv
// Reads a burst of consecutive SDRAM words and forwards them, in order, into the
// SDRAM->USB FIFO; credits bound outstanding reads to the return-buffer depth.
module sdram_rd_fifo
  import sdram_rd_fifo_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = 4
) (
  input  logic              sdram_clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err_unexp,
  sdram_rd_fifo_if.master   bus
);

  localparam int CNT_W = cnt_w(SKID_DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(SKID_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, remaining_q;
  logic [CNT_W-1:0]  credit_q, credit_d, outst_q, outst_d;
  logic              rd_valid_q, err_q;
  logic              start_ok, accept, push, pop, unexp;
  logic              skid_empty;
  logic [DATA_W-1:0] skid_head;
  logic [CNT_W-1:0]  skid_count;

  assign start_ok = (state_q == ST_IDLE) && start && (length != '0);
  assign accept   = rd_valid_q && bus.rd_ready;
  assign push     = bus.rd_rvalid && (outst_q != '0);
  assign unexp    = bus.rd_rvalid && (outst_q == '0);
  assign pop      = !skid_empty && !bus.fifo_wfull;

  assign credit_d = credit_q - CNT_W'(accept) + CNT_W'(pop);
  assign outst_d  = outst_q + CNT_W'(accept) - CNT_W'(push);

  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_REQ;
      ST_REQ:   if (accept && (remaining_q == ADDR_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if ((outst_q == '0) && (skid_count == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Request valid is registered from next-cycle state and credit so it stays
  // stable while waiting for rd_ready; only a falling init_done withdraws it.
  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      credit_q    <= CREDIT_FULL;
      outst_q     <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      outst_q    <= outst_d;
      rd_valid_q <= (state_d == ST_REQ) && sdram_init_done && (credit_d != '0);
      if (start_ok) begin
        addr_q      <= start_addr;
        remaining_q <= length;
      end else if (accept) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - ADDR_W'(1);
      end
      if (unexp)         err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;
    end
  end

  sdram_rd_fifo_skid #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk   (sdram_clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.rd_rdata),
    .pop   (pop),
    .head  (skid_head),
    .empty (skid_empty),
    .count (skid_count)
  );

  assign bus.rd_addr    = addr_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.fifo_wen   = pop;
  assign bus.fifo_wdata = skid_empty ? '0 : skid_head;
  assign err_unexp      = err_q;

endmodule

// File: tb/tb_sdram_rd_fifo.sv
// Bench for sdram_rd_fifo: an SDRAM responder with per-burst latency, a FIFO sink,
// a table of directed bursts and hand-written reset / error / start-filter sequences.
module tb_sdram_rd_fifo;
  import sdram_rd_fifo_pkg::*;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst, init_done, start;
  logic [AW-1:0] start_addr, length;
  logic          busy, done, err_unexp;

  sdram_rd_fifo_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_rd_fifo #(.ADDR_W(AW), .DATA_W(DW), .SKID_DEPTH(SD)) dut (
    .sdram_clk       (clk),
    .rst             (rst),
    .sdram_init_done (init_done),
    .start           (start),
    .start_addr      (start_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .err_unexp       (err_unexp),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int due; } ret_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int            lat;
    int            rdy_alt;
    int            wf_at;
    int            wf_len;
    int            init_dly;
    int            exp_words;
    int            exp_dones;
    logic [AW-1:0] exp_last;
    int            exp_max;
  } vec_t;

  int checks = 0;
  int failures = 0;

  ret_t          pending[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] got[$];
  int  cyc = 0;
  int  done_cnt, inv_viol, init_low_req, hold_viol, max_inflight, accepts, writes;
  int  cur_lat = 1;
  bit  inj_req = 1'b0;
  bit  prev_req_pending = 1'b0;
  bit  prev_init = 1'b0;
  logic [AW-1:0] prev_addr;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_tallies();
    pending.delete();
    addr_log.delete();
    got.delete();
    done_cnt = 0; inv_viol = 0; init_low_req = 0; hold_viol = 0;
    max_inflight = 0; accepts = 0; writes = 0;
  endtask

  // SDRAM responder and FIFO sink: drive returns at the falling edge, then
  // record what the DUT will hand over at the next rising edge.
  initial begin
    bus.rd_rvalid = 1'b0;
    bus.rd_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.rd_rvalid = 1'b0;
      bus.rd_rdata  = '0;
      if (inj_req) begin
        bus.rd_rvalid = 1'b1;
        bus.rd_rdata  = 16'hDEAD;
        inj_req = 1'b0;
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
        bus.rd_rvalid = 1'b1;
        bus.rd_rdata  = pending[0].data;
        void'(pending.pop_front());
      end
      #1;
      if (bus.rd_valid && !init_done) init_low_req++;
      if (!rst && prev_req_pending && prev_init && !(bus.rd_valid && bus.rd_addr == prev_addr))
        hold_viol++;
      if (!rst && bus.rd_valid && bus.rd_ready) begin
        addr_log.push_back(bus.rd_addr);
        pending.push_back(ret_t'{data: mem_data(bus.rd_addr), due: cyc + cur_lat});
        accepts++;
      end
      if (!rst && bus.fifo_wen) begin
        got.push_back(bus.fifo_wdata);
        writes++;
      end
      if (done) done_cnt++;
      if (accepts - writes > SD) inv_viol++;
      if (accepts - writes > max_inflight) max_inflight = accepts - writes;
      prev_req_pending = !rst && bus.rd_valid && !bus.rd_ready;
      prev_addr = bus.rd_addr;
      prev_init = init_done;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(); n++; #2;
    end
    check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (6) begin tick(); #2; end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t, tail, derr, aerr;
    logic [AW-1:0] last;
    clear_tallies();
    cur_lat = v.lat;
    tick();
    start = 1'b1; start_addr = v.addr; length = v.len;
    init_done = (v.init_dly == 0);
    bus.rd_ready = (v.rdy_alt == 0);
    bus.fifo_wfull = 1'b0;
    #2;
    t = 1; tail = 0;
    while (t < 600 && tail < 6) begin
      tick();
      start = 1'b0;
      if (v.init_dly != 0 && t >= v.init_dly) init_done = 1'b1;
      bus.rd_ready   = (v.rdy_alt != 0) ? (t % 2 == 1) : 1'b1;
      bus.fifo_wfull = (v.wf_len != 0 && t >= v.wf_at && t < v.wf_at + v.wf_len);
      #2;
      if (t == 1) check($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'd1);
      if (done_cnt != 0) tail++;
      t++;
    end
    init_done = 1'b1; bus.rd_ready = 1'b1; bus.fifo_wfull = 1'b0;
    check($sformatf("v%0d_done_seen", idx), 32'(done_cnt != 0), 32'd1);
    check($sformatf("v%0d_words", idx), 32'(got.size()), 32'(v.exp_words));
    check($sformatf("v%0d_done_pulses", idx), 32'(done_cnt), 32'(v.exp_dones));
    derr = 0;
    foreach (got[i]) if (got[i] !== mem_data(v.addr + AW'(i))) derr++;
    check($sformatf("v%0d_data_order_errs", idx), 32'(derr), 32'd0);
    aerr = 0;
    foreach (addr_log[i]) if (addr_log[i] !== AW'(v.addr + AW'(i))) aerr++;
    check($sformatf("v%0d_addr_seq_errs", idx), 32'(aerr), 32'd0);
    last = (addr_log.size() > 0) ? addr_log[$] : '1;
    check($sformatf("v%0d_last_addr", idx), 32'(last), 32'(v.exp_last));
    check($sformatf("v%0d_req_while_init_low", idx), 32'(init_low_req), 32'd0);
    check($sformatf("v%0d_req_hold_viol", idx), 32'(hold_viol), 32'd0);
    check($sformatf("v%0d_credit_invariant_viol", idx), 32'(inv_viol), 32'd0);
    if (v.exp_max != 0)
      check($sformatf("v%0d_max_inflight", idx), 32'(max_inflight), 32'(v.exp_max));
    check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_err_unexp", idx), 32'(err_unexp), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int busy_cnt;
    vecs[0] = '{22'h000100, 22'd8,  3, 0, 0, 0,  0,  8, 1, 22'h000107, 4};
    vecs[1] = '{22'h002000, 22'd16, 2, 0, 6, 20, 0, 16, 1, 22'h00200F, 4};
    vecs[2] = '{22'h3FFFFE, 22'd4,  1, 0, 0, 0,  0,  4, 1, 22'h000001, 0};
    vecs[3] = '{22'h000055, 22'd5,  4, 0, 0, 0,  10, 5, 1, 22'h000059, 0};
    vecs[4] = '{22'h001234, 22'd6,  2, 1, 0, 0,  0,  6, 1, 22'h001239, 0};

    rst = 1'b1; init_done = 1'b1; start = 1'b0;
    start_addr = '0; length = '0;
    bus.rd_ready = 1'b1; bus.fifo_wfull = 1'b0;
    clear_tallies();
    repeat (3) tick();
    #2;
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_done",       32'(done),           32'd0);
    check("rst_err_unexp",  32'(err_unexp),      32'd0);
    check("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
    check("rst_rd_addr",    32'(bus.rd_addr),    32'd0);
    check("rst_fifo_wen",   32'(bus.fifo_wen),   32'd0);
    check("rst_fifo_wdata", 32'(bus.fifo_wdata), 32'd0);
    tick(); rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Zero-length start is a no-op.
    clear_tallies();
    tick(); start = 1'b1; start_addr = 22'h000077; length = '0;
    busy_cnt = 0;
    repeat (6) begin
      tick(); start = 1'b0; #2;
      if (busy) busy_cnt++;
    end
    check("len0_busy_cycles", 32'(busy_cnt), 32'd0);
    check("len0_done_pulses", 32'(done_cnt), 32'd0);
    check("len0_requests",    32'(addr_log.size()), 32'd0);

    // A start while busy is ignored.
    clear_tallies(); cur_lat = 2;
    tick(); start = 1'b1; start_addr = 22'h000010; length = 22'd3;
    tick(); start = 1'b0;
    tick(); start = 1'b1; start_addr = 22'h000900; length = 22'd7;
    tick(); start = 1'b0;
    #2;
    wait_done("busy_start", 200);
    check("busy_start_words",      32'(got.size()), 32'd3);
    check("busy_start_first_addr", 32'((addr_log.size() > 0) ? addr_log[0] : '1), 32'h10);
    check("busy_start_last_addr",  32'((addr_log.size() > 0) ? addr_log[$] : '1), 32'h12);
    check("busy_start_done",       32'(done_cnt), 32'd1);

    // Return with nothing outstanding is flagged until the next accepted start.
    clear_tallies();
    tick(); #2; inj_req = 1'b1;
    tick(); tick(); #2;
    check("unexp_set", 32'(err_unexp), 32'd1);
    repeat (4) tick();
    #2;
    check("unexp_sticky", 32'(err_unexp), 32'd1);
    cur_lat = 2;
    tick(); start = 1'b1; start_addr = 22'h000040; length = 22'd2;
    tick(); start = 1'b0; #2;
    check("unexp_cleared_by_start", 32'(err_unexp), 32'd0);
    wait_done("unexp_burst", 200);
    check("unexp_burst_words", 32'(got.size()), 32'd2);

    // Reset in the middle of a burst aborts at once.
    clear_tallies(); cur_lat = 2;
    tick(); start = 1'b1; start_addr = 22'h000500; length = 22'd12;
    tick(); start = 1'b0;
    repeat (7) tick();
    #2;
    check("midrst_busy_before",   32'(busy), 32'd1);
    check("midrst_words_before",  32'(got.size() > 0), 32'd1);
    tick(); rst = 1'b1; pending.delete();
    #1;
    check("midrst_busy",       32'(busy),           32'd0);
    check("midrst_done",       32'(done),           32'd0);
    check("midrst_rd_valid",   32'(bus.rd_valid),   32'd0);
    check("midrst_rd_addr",    32'(bus.rd_addr),    32'd0);
    check("midrst_fifo_wen",   32'(bus.fifo_wen),   32'd0);
    check("midrst_fifo_wdata", 32'(bus.fifo_wdata), 32'd0);
    check("midrst_err_unexp",  32'(err_unexp),      32'd0);
    tick(); rst = 1'b0;
    clear_tallies();
    #2; inj_req = 1'b1;
    tick(); tick(); #2;
    check("late_return_err", 32'(err_unexp), 32'd1);
    check("late_return_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
